// File: rtl/arb2_4bits_pkg.sv
// Shared arbiter constants: state encodings and the default burst limit.
package arb2_4bits_pkg;

   localparam int unsigned MAX_BURST_DEF = 4;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_OWN0 = 2'b01;
   localparam logic [1:0] ST_OWN1 = 2'b10;

   function automatic logic [1:0] own_state(input logic who);
      return who ? ST_OWN1 : ST_OWN0;
   endfunction

endpackage

// File: rtl/mx2_4bits.sv
// 4-bit 2:1 multiplexer: y = b when s is high, else a.
module mx2_4bits (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       s,
   output logic [3:0] y
);

   assign y = s ? b : a;

endmodule

// File: rtl/arb2_4bits.sv
// Two-requester burst-limited arbiter with a shared 4-bit data channel.
module arb2_4bits
   import arb2_4bits_pkg::*;
#(
   parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req0,
   input  logic       req1,
   input  logic [3:0] d0,
   input  logic [3:0] d1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       valid,
   output logic [3:0] y
);

   localparam logic [2:0] MAX_CNT = 3'(MAX_BURST);

   logic [1:0] state, next_state;
   logic [2:0] cnt, next_cnt;
   logic       last, next_last;
   logic       winner, holder, mine, other;
   logic [3:0] mux_y;

   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      next_last  = last;
      winner     = 1'b0;
      holder     = (state == ST_OWN1);
      mine       = holder ? req1 : req0;
      other      = holder ? req0 : req1;
      case (state)
         ST_IDLE: begin
            if (req0 || req1) begin
               // on a tie the requester that did not own last time wins
               winner     = (req0 && req1) ? ~last : req1;
               next_state = own_state(winner);
               next_cnt   = 3'd1;
               next_last  = winner;
            end
         end
         ST_OWN0, ST_OWN1: begin
            if (!mine || (cnt == MAX_CNT && other)) begin
               if (other) begin
                  next_state = own_state(~holder);
                  next_cnt   = 3'd1;
                  next_last  = ~holder;
               end else begin
                  next_state = ST_IDLE;
                  next_cnt   = 3'd0;
               end
            end else if (cnt == MAX_CNT) begin
               next_cnt = 3'd1;
            end else begin
               next_cnt = cnt + 3'd1;
            end
         end
         default: begin
            next_state = ST_IDLE;
            next_cnt   = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         cnt   <= 3'd0;
         last  <= 1'b1;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
         last  <= next_last;
      end
   end

   assign gnt0  = (state == ST_OWN0);
   assign gnt1  = (state == ST_OWN1);
   assign valid = gnt0 | gnt1;

   mx2_4bits u_mux (
      .a (d0),
      .b (d1),
      .s (gnt1),
      .y (mux_y)
   );

   assign y = mux_y & {4{valid}};

endmodule

// File: tb/tb_arb2_4bits.sv
// Self-checking bench for arb2_4bits: directed scenarios plus a random run against a behavioural model.
module tb_arb2_4bits;

   localparam int MAXB = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [3:0] d0 = '0, d1 = '0;
   logic       gnt0, gnt1, valid;
   logic [3:0] y;

   int vectors = 0;
   int miscompares = 0;

   // model: owner -1 idle, 0 or 1 requester index; run = consecutive cycles held
   int m_owner = -1;
   int m_run = 0;
   int m_last = 1;

   arb2_4bits #(.MAX_BURST(MAXB)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .req0    (req0),
      .req1    (req1),
      .d0      (d0),
      .d1      (d1),
      .gnt0    (gnt0),
      .gnt1    (gnt1),
      .valid   (valid),
      .y       (y)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit expired, got no finish, required finish");
      $fatal(1, "timeout");
   end

   task automatic model_reset();
      m_owner = -1;
      m_run   = 0;
      m_last  = 1;
   endtask

   task automatic model_step(input logic r0, input logic r1);
      bit r[2];
      int h;
      r[0] = r0;
      r[1] = r1;
      if (m_owner < 0) begin
         if (r0 || r1) begin
            m_owner = (r0 && r1) ? (1 - m_last) : (r1 ? 1 : 0);
            m_run   = 1;
            m_last  = m_owner;
         end
      end else begin
         h = m_owner;
         if (!r[h] || (m_run == MAXB && r[1-h])) begin
            if (r[1-h]) begin
               m_owner = 1 - h;
               m_run   = 1;
               m_last  = m_owner;
            end else begin
               m_owner = -1;
               m_run   = 0;
            end
         end else if (m_run == MAXB) begin
            m_run = 1;
         end else begin
            m_run = m_run + 1;
         end
      end
   endtask

   // drive at a negedge, let one rising edge pass, return at the next negedge
   task automatic drive_cycle(input logic r0, input logic r1, input logic [3:0] a, input logic [3:0] b);
      req0 = r0;
      req1 = r1;
      d0   = a;
      d1   = b;
      @(posedge clk);
      if (reset_n) model_step(r0, r1);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      req0 = 1'b0;
      req1 = 1'b0;
      reset_n = 1'b0;
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      req0 = 1'b1;
      d0 = 4'hF;
      #3;
      vectors++;
      if ({gnt0, gnt1, valid, y} !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: got gnt0=%b gnt1=%b valid=%b y=%h, required all zero", gnt0, gnt1, valid, y);
      end
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      drive_cycle(1'b1, 1'b0, 4'hF, 4'h0);
      vectors++;
      if (gnt0 !== 1'b1 || y !== 4'hF) begin
         miscompares++;
         $display("FAIL reset_resume: got gnt0=%b y=%h, required gnt0=1 y=f", gnt0, y);
      end
   endtask

   task automatic test_single();
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b1, 1'b0, 4'hA, 4'h3);
         vectors++;
         if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || valid !== 1'b1 || y !== 4'hA) begin
            miscompares++;
            $display("FAIL single_grant[%0d]: got gnt0=%b gnt1=%b valid=%b y=%h, required 1 0 1 a", i, gnt0, gnt1, valid, y);
         end
      end
      req0 = 1'b0;
      #1;
      vectors++;
      if (y !== 4'hA) begin
         miscompares++;
         $display("FAIL drop_same_cycle: got y=%h, required a", y);
      end
      drive_cycle(1'b0, 1'b0, 4'hA, 4'h3);
      vectors++;
      if (gnt0 !== 1'b0 || valid !== 1'b0 || y !== 4'h0) begin
         miscompares++;
         $display("FAIL single_release: got gnt0=%b valid=%b y=%h, required 0 0 0", gnt0, valid, y);
      end
   endtask

   task automatic test_alternate();
      int exp_owner;
      apply_reset();
      for (int k = 0; k < 24; k++) begin
         drive_cycle(1'b1, 1'b1, 4'h3, 4'hC);
         exp_owner = ((k / MAXB) % 2 == 0) ? 0 : 1;
         vectors++;
         if (gnt0 !== (exp_owner == 0) || gnt1 !== (exp_owner == 1) ||
             y !== ((exp_owner == 0) ? 4'h3 : 4'hC)) begin
            miscompares++;
            $display("FAIL alternate[%0d]: got gnt0=%b gnt1=%b y=%h, required owner %0d", k, gnt0, gnt1, y, exp_owner);
         end
      end
   endtask

   task automatic test_handover();
      apply_reset();
      drive_cycle(1'b1, 1'b1, 4'h9, 4'h5);
      drive_cycle(1'b1, 1'b1, 4'h9, 4'h5);
      drive_cycle(1'b0, 1'b1, 4'h9, 4'h5);
      vectors++;
      if (gnt0 !== 1'b0 || gnt1 !== 1'b1 || y !== 4'h5) begin
         miscompares++;
         $display("FAIL handover: got gnt0=%b gnt1=%b y=%h, required 0 1 5", gnt0, gnt1, y);
      end
   endtask

   task automatic test_req1_alone();
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         drive_cycle(1'b0, 1'b1, 4'h0, 4'h6);
         vectors++;
         if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || y !== 4'h6) begin
            miscompares++;
            $display("FAIL req1_alone[%0d]: got gnt0=%b gnt1=%b y=%h, required 0 1 6", i, gnt0, gnt1, y);
         end
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      drive_cycle(1'b0, 1'b1, 4'h0, 4'h7);
      drive_cycle(1'b0, 1'b1, 4'h0, 4'h7);
      #2;
      reset_n = 1'b0;
      #1;
      vectors++;
      if (gnt1 !== 1'b0 || valid !== 1'b0 || y !== 4'h0) begin
         miscompares++;
         $display("FAIL async_reset: got gnt1=%b valid=%b y=%h, required 0 0 0", gnt1, valid, y);
      end
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      drive_cycle(1'b1, 1'b1, 4'h2, 4'h7);
      vectors++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || y !== 4'h2) begin
         miscompares++;
         $display("FAIL post_reset_tie: got gnt0=%b gnt1=%b y=%h, required 1 0 2", gnt0, gnt1, y);
      end
   endtask

   task automatic test_random();
      int wait0, wait1;
      logic [3:0] exp_y;
      apply_reset();
      wait0 = 0;
      wait1 = 0;
      for (int n = 0; n < 1000; n++) begin
         req0 = ($urandom_range(0, 9) < 7);
         req1 = ($urandom_range(0, 9) < 7);
         d0   = 4'($urandom);
         d1   = 4'($urandom);
         #1;
         exp_y = (m_owner == 0) ? d0 : (m_owner == 1) ? d1 : 4'h0;
         vectors++;
         if (gnt0 !== (m_owner == 0) || gnt1 !== (m_owner == 1) ||
             valid !== (m_owner >= 0) || y !== exp_y) begin
            miscompares++;
            $display("FAIL random[%0d]: got gnt0=%b gnt1=%b valid=%b y=%h, required owner %0d y=%h",
                     n, gnt0, gnt1, valid, y, m_owner, exp_y);
         end
         vectors++;
         if (gnt0 === 1'b1 && gnt1 === 1'b1) begin
            miscompares++;
            $display("FAIL exclusive[%0d]: got gnt0=1 gnt1=1, required at most one", n);
         end
         if (req0 && gnt1) wait0++;
         else if (!req0 || gnt0) wait0 = 0;
         if (req1 && gnt0) wait1++;
         else if (!req1 || gnt1) wait1 = 0;
         vectors++;
         if (wait0 > MAXB || wait1 > MAXB) begin
            miscompares++;
            $display("FAIL wait_bound[%0d]: got wait0=%0d wait1=%0d, required <= %0d", n, wait0, wait1, MAXB);
         end
         @(posedge clk);
         model_step(req0, req1);
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_alternate();
      test_handover();
      test_req1_alone();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
